n_of_kind_detector: RTL and testbench

//   Parametrised successor to the pair/triple detector. Scans a stream of SYM_W-bit

---
 rtl/nok_det_pkg.sv | 30 +++
 rtl/n_of_kind_detector_window.sv | 64 ++++++
 rtl/n_of_kind_detector.sv | 120 ++++++++++++
 tb/tb_n_of_kind_detector.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/nok_det_pkg.sv
// Shared types and constants for the n-of-a-kind detector.
package nok_det_pkg;

    typedef enum logic [1:0] {
        KIND_NONE   = 2'd0,
        KIND_PAIR   = 2'd1,
        KIND_TRIPLE = 2'd2,
        KIND_QUAD   = 2'd3
    } kind_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    localparam logic [7:0] HIT_MAX = 8'd255;

    // Map a match count (including the presented sample) onto a result kind.
    function automatic kind_e count_to_kind(input int unsigned count);
        if (count >= 4)
            return KIND_QUAD;
        else if (count == 3)
            return KIND_TRIPLE;
        else if (count == 2)
            return KIND_PAIR;
        else
            return KIND_NONE;
    endfunction

endpackage

// File: rtl/n_of_kind_detector_window.sv
// Sample window: DEPTH-entry shift register with fill tracking and a
// mode-dependent match counter for the symbol currently presented.
module symbol_window
    import nok_det_pkg::*;
#(
    parameter int unsigned SYM_W = 4,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             mode,
    input  logic [SYM_W-1:0] sym,
    output kind_e            kind
);

    localparam int unsigned FILL_W = $clog2(DEPTH + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

    logic [SYM_W-1:0]  win [DEPTH];
    logic [FILL_W-1:0] fill;
    int unsigned       match_cnt;
    logic              run_alive;

    // Fill counter: flushed by reset/clear, saturates once the window is full.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            fill <= '0;
        end else if (shift_en && (fill != FILL_FULL)) begin
            fill <= fill + 1'b1;
        end
    end

    // Shift register, newest sample at index 0; stale entries are masked by fill.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            win[0] <= sym;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                win[i] <= win[i-1];
            end
        end
    end

    // Count matches for the presented symbol: all valid entries (mode=1)
    // or only the unbroken run at the newest end (mode=0).
    always_comb begin
        match_cnt = 1;
        run_alive = 1'b1;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (FILL_W'(i) < fill) begin
                if (win[i] == sym) begin
                    if (mode || run_alive) begin
                        match_cnt = match_cnt + 1;
                    end
                end else begin
                    run_alive = 1'b0;
                end
            end
        end
        kind = count_to_kind(match_cnt);
    end

endmodule

// File: rtl/n_of_kind_detector.sv
// Pair/triple/four-of-a-kind detector: window match counting feeds a
// two-state hold FSM that latches, upgrades and times out the result.
module n_of_kind_detector
    import nok_det_pkg::*;
#(
    parameter int unsigned SYM_W     = 4,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned MAX_COUNT = 10000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [SYM_W-1:0] in_sym,
    input  logic             mode,
    input  logic             clear,
    output logic             match_valid,
    output logic [1:0]       match_kind,
    output logic [SYM_W-1:0] match_sym,
    output logic             busy,
    output logic [7:0]       hit_count
);

    localparam int unsigned CNT_W = $clog2(MAX_COUNT + 1);
    localparam logic [CNT_W-1:0] TIMER_LOAD = CNT_W'(MAX_COUNT - 1);

    state_e           state, state_nxt;
    kind_e            win_kind, new_kind;
    kind_e            held_kind, held_kind_nxt;
    logic [SYM_W-1:0] held_sym, held_sym_nxt;
    logic [CNT_W-1:0] timer, timer_nxt;
    logic             pulse_nxt;
    logic             accept;

    // clear wins over in_valid: the sample is dropped, not shifted in.
    assign accept = in_valid && !clear;

    symbol_window #(
        .SYM_W (SYM_W),
        .DEPTH (DEPTH)
    ) u_window (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .shift_en (accept),
        .mode     (mode),
        .sym      (in_sym),
        .kind     (win_kind)
    );

    // Next-state logic: latch on first hit, upgrade while held, expire on timer.
    always_comb begin
        state_nxt     = state;
        held_kind_nxt = held_kind;
        held_sym_nxt  = held_sym;
        timer_nxt     = timer;
        pulse_nxt     = 1'b0;
        new_kind      = accept ? win_kind : KIND_NONE;

        case (state)
            ST_IDLE: begin
                if (new_kind != KIND_NONE) begin
                    state_nxt     = ST_HOLD;
                    held_kind_nxt = new_kind;
                    held_sym_nxt  = in_sym;
                    timer_nxt     = TIMER_LOAD;
                    pulse_nxt     = 1'b1;
                end
            end
            ST_HOLD: begin
                // An upgrade on the expiry cycle keeps the hold alive.
                if (new_kind > held_kind) begin
                    held_kind_nxt = new_kind;
                    held_sym_nxt  = in_sym;
                    timer_nxt     = TIMER_LOAD;
                    pulse_nxt     = 1'b1;
                end else if (timer == '0) begin
                    state_nxt     = ST_IDLE;
                    held_kind_nxt = KIND_NONE;
                    held_sym_nxt  = '0;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, timer and held result registers; clear/reset flush them.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state       <= ST_IDLE;
            held_kind   <= KIND_NONE;
            held_sym    <= '0;
            timer       <= '0;
            match_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            held_kind   <= held_kind_nxt;
            held_sym    <= held_sym_nxt;
            timer       <= timer_nxt;
            match_valid <= pulse_nxt;
        end
    end

    // Saturating pulse counter; survives clear, only reset zeroes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count <= '0;
        end else if (pulse_nxt && (hit_count != HIT_MAX)) begin
            hit_count <= hit_count + 1'b1;
        end
    end

    assign match_kind = held_kind;
    assign match_sym  = held_sym;
    assign busy       = (state == ST_HOLD);

endmodule

// File: tb/tb_n_of_kind_detector.sv
module tb_n_of_kind_detector;

    localparam int SYM_W     = 4;
    localparam int DEPTH     = 8;
    localparam int MAX_COUNT = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [SYM_W-1:0] in_sym;
    logic             mode;
    logic             clear;
    logic             match_valid;
    logic [1:0]       match_kind;
    logic [SYM_W-1:0] match_sym;
    logic             busy;
    logic [7:0]       hit_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: history of accepted symbols (oldest first) plus held result.
    int hist[$];
    int m_kind, m_sym, m_left, m_hit;
    bit m_mv;

    n_of_kind_detector #(
        .SYM_W     (SYM_W),
        .DEPTH     (DEPTH),
        .MAX_COUNT (MAX_COUNT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_sym      (in_sym),
        .mode        (mode),
        .clear       (clear),
        .match_valid (match_valid),
        .match_kind  (match_kind),
        .match_sym   (match_sym),
        .busy        (busy),
        .hit_count   (hit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int ref_kind(int s, bit md);
        int cnt = 1;
        if (md) begin
            foreach (hist[i]) if (hist[i] == s) cnt++;
        end else begin
            for (int i = hist.size() - 1; i >= 0; i--) begin
                if (hist[i] != s) break;
                cnt++;
            end
        end
        return (cnt >= 4) ? 3 : cnt - 1;
    endfunction

    // Apply one cycle of stimulus, advance the model, then settle past the edge.
    task automatic step(input bit v, input int s, input bit md, input bit clr);
        int k;
        in_valid = v;
        in_sym   = SYM_W'(s);
        mode     = md;
        clear    = clr;
        @(posedge clk);
        if (rst) begin
            hist.delete();
            m_kind = 0; m_sym = 0; m_left = 0; m_hit = 0; m_mv = 0;
        end else if (clr) begin
            hist.delete();
            m_kind = 0; m_sym = 0; m_left = 0; m_mv = 0;
        end else begin
            k = v ? ref_kind(s, md) : 0;
            if (v) begin
                hist.push_back(s);
                if (hist.size() > DEPTH) void'(hist.pop_front());
            end
            if (k > m_kind) begin
                m_mv = 1; m_kind = k; m_sym = s; m_left = MAX_COUNT;
                if (m_hit < 255) m_hit++;
            end else begin
                m_mv = 0;
                if (m_left > 0) m_left--;
                if (m_left == 0) begin m_kind = 0; m_sym = 0; end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        rst = 1'b0;
        n_checks++; if (match_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mv: got %0b want 0", match_valid); end
        n_checks++; if (match_kind !== 2'd0) begin n_fail++; $display("FAIL reset_kind: got %0d want 0", match_kind); end
        n_checks++; if (match_sym !== 4'd0) begin n_fail++; $display("FAIL reset_sym: got %0d want 0", match_sym); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_checks++; if (hit_count !== 8'd0) begin n_fail++; $display("FAIL reset_hit: got %0d want 0", hit_count); end
    endtask

    task automatic test_window_pair();
        step(0, 0, 1, 1);
        step(1, 3, 1, 0);
        step(1, 5, 1, 0);
        n_checks++; if (match_valid !== 1'b0) begin n_fail++; $display("FAIL pair_early: got %0b want 0", match_valid); end
        step(1, 3, 1, 0);
        n_checks++; if (match_valid !== 1'b1) begin n_fail++; $display("FAIL pair_mv: got %0b want 1", match_valid); end
        n_checks++; if (match_kind !== 2'd1) begin n_fail++; $display("FAIL pair_kind: got %0d want 1", match_kind); end
        n_checks++; if (match_sym !== 4'd3) begin n_fail++; $display("FAIL pair_sym: got %0d want 3", match_sym); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pair_busy: got %0b want 1", busy); end
        step(0, 0, 1, 0);
        n_checks++; if (match_valid !== 1'b0) begin n_fail++; $display("FAIL pair_one_cycle: got %0b want 0", match_valid); end
        repeat (4) step(0, 0, 1, 0);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pair_expire: got %0b want 0", busy); end
    endtask

    task automatic test_upgrade();
        int hit0;
        step(0, 0, 1, 1);
        hit0 = int'(hit_count);
        step(1, 7, 1, 0);
        step(1, 7, 1, 0);
        n_checks++; if (match_valid !== 1'b1 || match_kind !== 2'd1) begin n_fail++; $display("FAIL upg_pair: got mv=%0b kind=%0d want mv=1 kind=1", match_valid, match_kind); end
        step(1, 7, 1, 0);
        n_checks++; if (match_valid !== 1'b1 || match_kind !== 2'd2) begin n_fail++; $display("FAIL upg_triple: got mv=%0b kind=%0d want mv=1 kind=2", match_valid, match_kind); end
        for (int c = 1; c <= 3; c++) begin
            step(0, 0, 1, 0);
            n_checks++; if (busy !== 1'b1 || match_kind !== 2'd2) begin n_fail++; $display("FAIL upg_hold_%0d: got busy=%0b kind=%0d want busy=1 kind=2", c, busy, match_kind); end
        end
        step(0, 0, 1, 0);
        n_checks++; if (busy !== 1'b0 || match_kind !== 2'd0 || match_sym !== 4'd0) begin n_fail++; $display("FAIL upg_drop: got busy=%0b kind=%0d sym=%0d want 0 0 0", busy, match_kind, match_sym); end
        n_checks++; if (int'(hit_count) !== ((hit0 + 2 > 255) ? 255 : hit0 + 2)) begin n_fail++; $display("FAIL upg_hits: got %0d want %0d", hit_count, hit0 + 2); end
    endtask

    task automatic test_run_mode();
        int seq[5] = '{2, 9, 2, 2, 2};
        int exp_mv[5] = '{0, 0, 0, 1, 1};
        int exp_k[5]  = '{0, 0, 0, 1, 2};
        step(0, 0, 0, 1);
        foreach (seq[i]) begin
            step(1, seq[i], 0, 0);
            n_checks++;
            if (match_valid !== 1'(exp_mv[i]) || match_kind !== 2'(exp_k[i])) begin
                n_fail++; $display("FAIL run_%0d: got mv=%0b kind=%0d want mv=%0d kind=%0d", i, match_valid, match_kind, exp_mv[i], exp_k[i]);
            end
        end
        repeat (5) step(0, 0, 0, 0);
    endtask

    task automatic test_age_out();
        step(0, 0, 1, 1);
        step(1, 1, 1, 0);
        for (int s = 2; s <= 9; s++) step(1, s, 1, 0);
        step(1, 1, 1, 0);
        n_checks++; if (match_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL age_out: got mv=%0b busy=%0b want 0 0", match_valid, busy); end
        step(1, 1, 1, 0);
        n_checks++; if (match_valid !== 1'b1 || match_kind !== 2'd1) begin n_fail++; $display("FAIL age_refill: got mv=%0b kind=%0d want 1 1", match_valid, match_kind); end
        repeat (5) step(0, 0, 1, 0);
    endtask

    task automatic test_hold_ignore_and_clear();
        int hit0;
        step(0, 0, 1, 1);
        repeat (3) step(1, 7, 1, 0);
        hit0 = int'(hit_count);
        step(1, 4, 1, 0);
        step(1, 4, 1, 0);
        n_checks++; if (match_valid !== 1'b0 || match_kind !== 2'd2 || match_sym !== 4'd7) begin n_fail++; $display("FAIL ignore: got mv=%0b kind=%0d sym=%0d want 0 2 7", match_valid, match_kind, match_sym); end
        n_checks++; if (int'(hit_count) !== hit0) begin n_fail++; $display("FAIL ignore_hits: got %0d want %0d", hit_count, hit0); end
        step(1, 6, 1, 1);
        n_checks++; if (busy !== 1'b0 || match_kind !== 2'd0 || match_valid !== 1'b0) begin n_fail++; $display("FAIL clear: got busy=%0b kind=%0d mv=%0b want 0 0 0", busy, match_kind, match_valid); end
        n_checks++; if (int'(hit_count) !== hit0) begin n_fail++; $display("FAIL clear_hits: got %0d want %0d", hit_count, hit0); end
        step(1, 6, 1, 0);
        n_checks++; if (match_valid !== 1'b0) begin n_fail++; $display("FAIL clear_dropped: got %0b want 0", match_valid); end
        step(1, 6, 1, 0);
        n_checks++; if (match_valid !== 1'b1 || match_sym !== 4'd6) begin n_fail++; $display("FAIL clear_refill: got mv=%0b sym=%0d want 1 6", match_valid, match_sym); end
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 260; n++) begin
            step(0, 0, 1, 1);
            step(1, 5, 1, 0);
            step(1, 5, 1, 0);
        end
        n_checks++; if (hit_count !== 8'd255) begin n_fail++; $display("FAIL sat_hits: got %0d want 255", hit_count); end
        n_checks++; if (int'(hit_count) !== m_hit) begin n_fail++; $display("FAIL sat_model: got %0d want %0d", hit_count, m_hit); end
        rst = 1'b1;
        step(0, 0, 1, 0);
        rst = 1'b0;
        n_checks++; if (hit_count !== 8'd0) begin n_fail++; $display("FAIL sat_reset: got %0d want 0", hit_count); end
    endtask

    task automatic test_random();
        bit v, md, clr;
        int s;
        md = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            v   = ($urandom_range(0, 9) < 7);
            s   = $urandom_range(0, 3);
            clr = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 49) == 0) md = ~md;
            step(v, s, md, clr);
            n_checks++;
            if (match_valid !== m_mv || match_kind !== 2'(m_kind) || match_sym !== SYM_W'(m_sym) ||
                busy !== (m_left > 0) || hit_count !== 8'(m_hit)) begin
                n_fail++;
                $display("FAIL rand_%0d: got mv=%0b kind=%0d sym=%0d busy=%0b hit=%0d want mv=%0b kind=%0d sym=%0d busy=%0b hit=%0d",
                         n, match_valid, match_kind, match_sym, busy, hit_count,
                         m_mv, m_kind, m_sym, (m_left > 0), m_hit);
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sym = '0; mode = 1'b0; clear = 1'b0;
        test_reset();
        test_window_pair();
        test_upgrade();
        test_run_mode();
        test_age_out();
        test_hold_ignore_and_clear();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
